// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned MEMOP_WIDTH = 4;

  typedef enum logic [MEMOP_WIDTH-1:0] {
    OpNone = 4'd0,
    OpLb   = 4'd1,
    OpLh   = 4'd2,
    OpLw   = 4'd3,
    OpLd   = 4'd4,
    OpLbu  = 4'd5,
    OpLhu  = 4'd6,
    OpLwu  = 4'd7,
    OpSb   = 4'd8,
    OpSh   = 4'd9,
    OpSw   = 4'd10,
    OpSd   = 4'd11
  } mem_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_t;

  // log2 of the access size in bytes.
  function automatic logic [2:0] mem_size(input mem_op_t op);
    case (op)
      OpLb, OpLbu, OpSb: return 3'd0;
      OpLh, OpLhu, OpSh: return 3'd1;
      OpLw, OpLwu, OpSw: return 3'd2;
      default:           return 3'd3;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw) || (op == OpSd);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store strobe/data shift and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_op_t     st_op,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata,
  output logic [7:0]  st_strobe,
  output logic [63:0] st_data,
  input  mem_op_t     ld_op,
  input  logic [2:0]  ld_off,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_result
);

  logic [7:0]  mask;
  logic [63:0] raw;

  // Store side: byte enables and data moved into the addressed lanes.
  always_comb begin
    case (mem_size(st_op))
      3'd0:    mask = 8'h01;
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    st_strobe = is_store(st_op) ? (mask << st_off) : 8'h00;
    st_data   = st_wdata << {st_off, 3'b000};
  end

  // Load side: shift the addressed bytes down, then sign/zero extend.
  always_comb begin
    raw = ld_rdata >> {ld_off, 3'b000};
    case (ld_op)
      OpLb:    ld_result = {{56{raw[7]}}, raw[7:0]};
      OpLh:    ld_result = {{48{raw[15]}}, raw[15:0]};
      OpLw:    ld_result = {{32{raw[31]}}, raw[31:0]};
      OpLd:    ld_result = raw;
      OpLbu:   ld_result = {56'd0, raw[7:0]};
      OpLhu:   ld_result = {48'd0, raw[15:0]};
      OpLwu:   ld_result = {32'd0, raw[31:0]};
      default: ld_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per rising edge of lsu_valid.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  mem_op_t         mem_op,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic [XLEN-1:0] lsu_out,
  output logic            lsu_finish,
  output logic            misalign
);

  lsu_state_t      state_q, state_d;
  logic            lsu_valid_q;
  mem_op_t         op_q, op_d;
  logic            skip_q, skip_d;
  logic            dreq_valid_q, dreq_valid_d;
  logic [XLEN-1:0] dreq_addr_q, dreq_addr_d;
  logic [2:0]      dreq_size_q, dreq_size_d;
  logic [7:0]      dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0] dreq_data_q, dreq_data_d;
  logic [XLEN-1:0] lsu_out_q, lsu_out_d;
  logic            misalign_q, misalign_d;

  logic            trigger;
  logic [2:0]      size;
  logic [3:0]      size_bytes;
  logic            unaligned;
  logic [7:0]      st_strobe;
  logic [63:0]     st_data;
  logic [63:0]     ld_result;

  assign trigger    = lsu_valid & ~lsu_valid_q;
  assign size       = mem_size(mem_op);
  assign size_bytes = 4'd1 << size;
  // Low address bits under (bytes-1); for size 3 the wrap of 0-1 gives 3'b111.
  assign unaligned  = |(addr[2:0] & (size_bytes[2:0] - 3'd1));

  lsu_align u_align (
    .st_op     (mem_op),
    .st_off    (addr[2:0]),
    .st_wdata  (wdata),
    .st_strobe (st_strobe),
    .st_data   (st_data),
    .ld_op     (op_q),
    .ld_off    (dreq_addr_q[2:0]),
    .ld_rdata  (dresp_data),
    .ld_result (ld_result)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    skip_d        = skip_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_size_d   = dreq_size_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    lsu_out_d     = lsu_out_q;
    misalign_d    = misalign_q;
    case (state_q)
      StIdle: begin
        if (trigger) begin
          op_d = mem_op;
          if (mem_op == OpNone) begin
            // Non-bus results wait one cycle so they finish like a best-case bus op.
            lsu_out_d = addr;
            skip_d    = 1'b1;
            state_d   = StWait;
          end else if (unaligned) begin
            lsu_out_d  = '0;
            misalign_d = 1'b1;
            skip_d     = 1'b1;
            state_d    = StWait;
          end else begin
            dreq_valid_d  = 1'b1;
            dreq_addr_d   = addr;
            dreq_size_d   = size;
            dreq_strobe_d = st_strobe;
            dreq_data_d   = st_data;
            skip_d        = 1'b0;
            state_d       = StReq;
          end
        end
      end
      StReq: begin
        if (dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          if (dresp_data_ok) begin
            lsu_out_d = ld_result;
            state_d   = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (skip_q) begin
          state_d = StDone;
        end else if (dresp_data_ok) begin
          lsu_out_d = ld_result;
          state_d   = StDone;
        end
      end
      StDone: begin
        misalign_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      lsu_valid_q   <= 1'b0;
      op_q          <= OpNone;
      skip_q        <= 1'b0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      lsu_out_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lsu_valid_q   <= lsu_valid;
      op_q          <= op_d;
      skip_q        <= skip_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_size_q   <= dreq_size_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      lsu_out_q     <= lsu_out_d;
      misalign_q    <= misalign_d;
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;
  assign lsu_out     = lsu_out_q;
  assign lsu_finish  = (state_q == StDone);
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic [63:0] addr;
  logic [63:0] wdata;
  mem_op_t     mem_op;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic [63:0] lsu_out;
  logic        lsu_finish;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  lsu #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .lsu_valid     (lsu_valid),
    .addr          (addr),
    .wdata         (wdata),
    .mem_op        (mem_op),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .lsu_out       (lsu_out),
    .lsu_finish    (lsu_finish),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Best-case load: trigger in T, request seen in T+1 with both acks, finish in T+2.
  task automatic best_load(input string tag, input mem_op_t op, input logic [63:0] a,
                           input logic [63:0] rd, input logic [63:0] exp);
    lsu_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    tick();
    check({tag, "_req_valid"}, 64'(dreq_valid), 64'd1);
    check({tag, "_req_strobe"}, 64'(dreq_strobe), 64'd0);
    check({tag, "_finish_t1"}, 64'(lsu_finish), 64'd0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = rd;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    check({tag, "_finish_t2"}, 64'(lsu_finish), 64'd1);
    check({tag, "_out"}, lsu_out, exp);
    check({tag, "_misalign"}, 64'(misalign), 64'd0);
    check({tag, "_valid_dropped"}, 64'(dreq_valid), 64'd0);
    lsu_valid = 1'b0;
    tick();
    check({tag, "_finish_gone"}, 64'(lsu_finish), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    lsu_valid     = 1'b0;
    addr          = '0;
    wdata         = '0;
    mem_op        = OpNone;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    tick();
    tick();
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_dreq_addr", dreq_addr, 64'd0);
    check("rst_lsu_out", lsu_out, 64'd0);
    check("rst_finish", 64'(lsu_finish), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    rst = 1'b0;
    tick();

    // LD, aligned, both acks in the first request cycle.
    lsu_valid = 1'b1;
    mem_op    = OpLd;
    addr      = 64'h8000_0008;
    tick();
    check("ld_req_valid", 64'(dreq_valid), 64'd1);
    check("ld_req_addr", dreq_addr, 64'h8000_0008);
    check("ld_req_size", 64'(dreq_size), 64'd3);
    check("ld_req_strobe", 64'(dreq_strobe), 64'd0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h1122_3344_5566_7788;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    check("ld_finish_t2", 64'(lsu_finish), 64'd1);
    check("ld_out", lsu_out, 64'h1122_3344_5566_7788);
    lsu_valid = 1'b0;
    tick();
    check("ld_finish_gone", 64'(lsu_finish), 64'd0);
    check("ld_out_held", lsu_out, 64'h1122_3344_5566_7788);

    // Byte loads from lane 3: sign vs zero extension.
    best_load("lb", OpLb, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    best_load("lbu", OpLbu, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    // Halfword from lane 2 with top bit set, and word from lane 4.
    best_load("lh", OpLh, 64'h8000_0002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
    best_load("lwu", OpLwu, 64'h8000_0004, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF);

    // SH to lane 6 with addr_ok held off for three cycles.
    lsu_valid = 1'b1;
    mem_op    = OpSh;
    addr      = 64'h8000_0006;
    wdata     = 64'h0000_0000_0000_ABCD;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("sh_valid_stable", 64'(dreq_valid), 64'd1);
      check("sh_strobe", 64'(dreq_strobe), 64'hC0);
      check("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
      check("sh_size", 64'(dreq_size), 64'd1);
      check("sh_addr", dreq_addr, 64'h8000_0006);
      check("sh_no_finish", 64'(lsu_finish), 64'd0);
      // Changing live inputs must not disturb the latched request.
      addr  = 64'h0;
      wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
    end
    check("sh_valid_before_ack", 64'(dreq_valid), 64'd1);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    check("sh_wait_valid_low", 64'(dreq_valid), 64'd0);
    check("sh_wait_no_finish", 64'(lsu_finish), 64'd0);
    tick();
    check("sh_wait_still", 64'(lsu_finish), 64'd0);
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    check("sh_finish", 64'(lsu_finish), 64'd1);
    lsu_valid = 1'b0;
    tick();
    check("sh_finish_gone", 64'(lsu_finish), 64'd0);

    // Misaligned LW: no bus request, finish at T+2 with misalign.
    lsu_valid = 1'b1;
    mem_op    = OpLw;
    addr      = 64'h8000_0002;
    tick();
    check("mis_no_req_t1", 64'(dreq_valid), 64'd0);
    check("mis_no_finish_t1", 64'(lsu_finish), 64'd0);
    tick();
    check("mis_no_req_t2", 64'(dreq_valid), 64'd0);
    check("mis_finish", 64'(lsu_finish), 64'd1);
    check("mis_flag", 64'(misalign), 64'd1);
    check("mis_out", lsu_out, 64'd0);
    lsu_valid = 1'b0;
    tick();
    check("mis_finish_gone", 64'(lsu_finish), 64'd0);
    check("mis_flag_cleared", 64'(misalign), 64'd0);

    // NONE passes the address through; level held 10 cycles gives one pulse.
    lsu_valid = 1'b1;
    mem_op    = OpNone;
    addr      = 64'h1234;
    pulses    = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("none_no_req", 64'(dreq_valid), 64'd0);
      if (lsu_finish) pulses++;
      if (i == 1) check("none_no_finish_t1", 64'(lsu_finish), 64'd0);
      if (i == 2) begin
        check("none_finish_t2", 64'(lsu_finish), 64'd1);
        check("none_out", lsu_out, 64'h1234);
      end
    end
    check("none_one_pulse", 64'(pulses), 64'd1);
    lsu_valid = 1'b0;
    tick();

    // Reset while waiting for data; a late data_ok must be ignored.
    lsu_valid = 1'b1;
    mem_op    = OpLd;
    addr      = 64'h8000_0010;
    tick();
    check("rw_req_valid", 64'(dreq_valid), 64'd1);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    check("rw_in_wait", 64'(dreq_valid), 64'd0);
    check("rw_addr_held", dreq_addr, 64'h8000_0010);
    rst       = 1'b1;
    lsu_valid = 1'b0;
    #1;
    check("rw_rst_valid", 64'(dreq_valid), 64'd0);
    check("rw_rst_addr", dreq_addr, 64'd0);
    check("rw_rst_out", lsu_out, 64'd0);
    check("rw_rst_finish", 64'(lsu_finish), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dresp_data_ok = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (lsu_finish) pulses++;
      tick();
    end
    check("rw_late_no_finish", 64'(pulses), 64'd0);
    check("rw_late_out", lsu_out, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
